// File: rtl/wave_synth_pkg.sv
// Shared types, constants and saturating arithmetic for the wave_synth test-signal generator.
package wave_pkg;

  localparam int DW    = 12;
  localparam int DIV_W = 16;
  localparam logic [DW-1:0] FULL_SCALE = '1;

  typedef enum logic [1:0] {
    TRI = 2'd0,
    SQR = 2'd1,
    SAW = 2'd2,
    DC  = 2'd3
  } shape_t;

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    FALL,
    WRAP,
    HOLD
  } state_t;

  // Amplitude only matters when bounds are computed, so the running set omits it.
  typedef struct packed {
    logic [DW-1:0]    mean;
    logic [DW-1:0]    step;
    logic [DIV_W-1:0] div;
    shape_t           shape;
  } act_t;

  typedef struct packed {
    logic [DW-1:0] amp;
    act_t          run;
  } cfg_t;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] lim);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] floor_v);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DW] || (d[DW-1:0] < floor_v)) return floor_v;
    return d[DW-1:0];
  endfunction

endpackage

// File: rtl/wave_synth_if.sv
// Configuration and sample-stream bundle between the wave_synth core and its user.
interface wave_synth_if #(
  parameter int DW    = 12,
  parameter int DIV_W = 16
);

  logic             enable;
  logic             cfg_load;
  logic [DW-1:0]    cfg_amp;
  logic [DW-1:0]    cfg_mean;
  logic [DW-1:0]    cfg_step;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_shape;

  logic [DW-1:0]    data_out;
  logic             sample_tick;
  logic             cycle_done;
  logic             cfg_pending;
  logic [DW-1:0]    hi_lvl;
  logic [DW-1:0]    lo_lvl;

  modport master (
    output enable, cfg_load, cfg_amp, cfg_mean, cfg_step, cfg_div, cfg_shape,
    input  data_out, sample_tick, cycle_done, cfg_pending, hi_lvl, lo_lvl
  );

  modport slave (
    input  enable, cfg_load, cfg_amp, cfg_mean, cfg_step, cfg_div, cfg_shape,
    output data_out, sample_tick, cycle_done, cfg_pending, hi_lvl, lo_lvl
  );

endinterface

// File: rtl/wave_synth_sample_divider.sv
// Sample-rate divider: one tick every i_div+1 clocks while enabled, count parked at 0 otherwise.
module sample_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  // >= rather than == so a divider shortened mid-count cannot run through the full counter range.
  assign o_tick = i_enable && (r_cnt >= i_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_enable || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wave_synth.sv
// Triangle/square/sawtooth/DC test-signal generator with shadowed configuration that
// only takes effect at a period boundary, so the output never glitches mid-period.
module wave_synth #(
  parameter int DW       = 12,
  parameter int DIV_W    = 16,
  parameter int CLK_FREQ = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  wave_synth_if.slave  bus
);

  import wave_pkg::*;

  if (CLK_FREQ <= 0 || DW != wave_pkg::DW || DIV_W != wave_pkg::DIV_W) begin : g_bad_params
    $error("wave_synth: DW/DIV_W must match wave_pkg and CLK_FREQ must be positive");
  end

  state_t        r_state, w_state;
  cfg_t          r_shadow, w_shadow;
  act_t          r_active, w_active;
  logic          r_pending, w_pending;
  logic [DW-1:0] r_acc, w_acc;
  logic [DW-1:0] r_data, w_data;
  logic [DW-1:0] r_hi, w_hi;
  logic [DW-1:0] r_lo, w_lo;
  logic          r_stick, w_stick;
  logic          r_done, w_done;
  logic          w_boundary;

  cfg_t          w_cfg_in;
  logic [DW-1:0] w_in_hi, w_in_lo, w_sh_hi, w_sh_lo, w_step;
  logic          w_tick;

  assign w_cfg_in = {bus.cfg_amp, bus.cfg_mean, bus.cfg_step, bus.cfg_div, bus.cfg_shape};

  // Bounds for both possible load sources are precomputed so a load and its bounds land together.
  assign w_in_hi = sat_add(w_cfg_in.run.mean, w_cfg_in.amp, FULL_SCALE);
  assign w_in_lo = sat_sub(w_cfg_in.run.mean, w_cfg_in.amp, '0);
  assign w_sh_hi = sat_add(r_shadow.run.mean, r_shadow.amp, FULL_SCALE);
  assign w_sh_lo = sat_sub(r_shadow.run.mean, r_shadow.amp, '0);
  assign w_step  = (r_active.step == '0) ? DW'(1) : r_active.step;

  sample_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (bus.enable),
    .i_div    (r_active.div),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_state    = r_state;
    w_shadow   = r_shadow;
    w_active   = r_active;
    w_pending  = r_pending;
    w_acc      = r_acc;
    w_data     = r_data;
    w_hi       = r_hi;
    w_lo       = r_lo;
    w_stick    = 1'b0;
    w_done     = 1'b0;
    w_boundary = 1'b0;

    if (bus.cfg_load) w_shadow = w_cfg_in;

    if (!bus.enable || r_state == IDLE) begin
      // Nothing is being generated yet, so configuration goes straight to the active set.
      w_state = IDLE;
      if (bus.cfg_load) begin
        w_active  = w_cfg_in.run;
        w_hi      = w_in_hi;
        w_lo      = w_in_lo;
        w_pending = 1'b0;
      end else if (r_pending) begin
        w_active  = r_shadow.run;
        w_hi      = w_sh_hi;
        w_lo      = w_sh_lo;
        w_pending = 1'b0;
      end
      w_data = w_lo;
      w_acc  = w_lo;
      if (bus.enable && w_tick) begin
        w_stick = 1'b1;
        w_state = ((w_hi == w_lo) || (w_active.shape == DC)) ? HOLD : RISE;
      end
    end else begin
      case (r_state)
        RISE: if (w_tick) begin
          w_stick = 1'b1;
          w_acc   = sat_add(r_acc, w_step, r_hi);
          w_data  = (r_active.shape == SQR) ? r_hi : w_acc;
          if (w_acc == r_hi) w_state = (r_active.shape == SAW) ? WRAP : FALL;
        end
        FALL: if (w_tick) begin
          w_stick = 1'b1;
          w_acc   = sat_sub(r_acc, w_step, r_lo);
          w_data  = (r_active.shape == SQR) ? r_lo : w_acc;
          if (w_acc == r_lo) begin
            w_done     = 1'b1;
            w_boundary = 1'b1;
          end
        end
        WRAP: if (w_tick) begin
          w_stick    = 1'b1;
          w_data     = r_lo;
          w_done     = 1'b1;
          w_boundary = 1'b1;
        end
        HOLD: if (w_tick) begin
          w_stick = 1'b1;
          if (r_pending) begin
            w_active  = r_shadow.run;
            w_hi      = w_sh_hi;
            w_lo      = w_sh_lo;
            w_pending = 1'b0;
          end
          if ((w_hi == w_lo) || (w_active.shape == DC)) begin
            w_data = w_active.mean;
          end else begin
            w_data  = w_lo;
            w_acc   = w_lo;
            w_state = RISE;
          end
        end
        default: w_state = IDLE;
      endcase

      if (w_boundary) begin
        if (r_pending) begin
          w_active  = r_shadow.run;
          w_hi      = w_sh_hi;
          w_lo      = w_sh_lo;
          w_pending = 1'b0;
        end
        w_acc   = w_lo;
        w_state = ((w_hi == w_lo) || (w_active.shape == DC)) ? HOLD : RISE;
      end

      // A load coinciding with a boundary stays pending for the following period.
      if (bus.cfg_load) w_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_acc     <= '0;
      r_data    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_stick   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shadow  <= w_shadow;
      r_active  <= w_active;
      r_pending <= w_pending;
      r_acc     <= w_acc;
      r_data    <= w_data;
      r_hi      <= w_hi;
      r_lo      <= w_lo;
      r_stick   <= w_stick;
      r_done    <= w_done;
    end
  end

  assign bus.data_out    = r_data;
  assign bus.sample_tick = r_stick;
  assign bus.cycle_done  = r_done;
  assign bus.cfg_pending = r_pending;
  assign bus.hi_lvl      = r_hi;
  assign bus.lo_lvl      = r_lo;

endmodule

// File: tb/tb_wave_synth.sv
// Directed, table-driven bench for wave_synth with hand-computed sample sequences.
module tb_wave_synth;

  logic clk;
  logic rst_n;

  wave_synth_if #(.DW(12), .DIV_W(16)) bus ();

  wave_synth #(.DW(12), .DIV_W(16), .CLK_FREQ(1000000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]        shape;
    logic [11:0]       amp;
    logic [11:0]       mean;
    logic [11:0]       step;
    logic [15:0]       div;
    logic [11:0]       hi;
    logic [11:0]       lo;
    logic [0:8][11:0]  seq;
    logic [0:8]        done;
  } vec_t;

  vec_t vecs[8];
  int   nVectors     = 0;
  int   nMiscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic loadCfg(input logic [1:0] shape, input logic [11:0] amp, input logic [11:0] mean,
                         input logic [11:0] st, input logic [15:0] div);
    bus.enable    = 1'b0;
    bus.cfg_shape = shape;
    bus.cfg_amp   = amp;
    bus.cfg_mean  = mean;
    bus.cfg_step  = st;
    bus.cfg_div   = div;
    bus.cfg_load  = 1'b1;
    stepClock();
    bus.cfg_load  = 1'b0;
  endtask

  task automatic waitTick(input string name);
    int cyc = 0;
    stepClock();
    while (!bus.sample_tick && cyc < 100) begin
      stepClock();
      cyc++;
    end
    if (!bus.sample_tick) checkOutput({name, " tick timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int got     = 0;
    int cyc     = 0;
    int lastCyc = 0;
    loadCfg(v.shape, v.amp, v.mean, v.step, v.div);
    checkOutput($sformatf("v%0d hi_lvl", idx), int'(bus.hi_lvl), int'(v.hi));
    checkOutput($sformatf("v%0d lo_lvl", idx), int'(bus.lo_lvl), int'(v.lo));
    checkOutput($sformatf("v%0d idle data", idx), int'(bus.data_out), int'(v.lo));
    bus.enable = 1'b1;
    while (got < 9 && cyc < 400) begin
      stepClock();
      cyc++;
      if (bus.sample_tick) begin
        checkOutput($sformatf("v%0d sample%0d", idx, got), int'(bus.data_out), int'(v.seq[got]));
        checkOutput($sformatf("v%0d done%0d", idx, got), int'(bus.cycle_done), int'(v.done[got]));
        if (got > 0) checkOutput($sformatf("v%0d spacing%0d", idx, got), cyc - lastCyc, int'(v.div) + 1);
        lastCyc = cyc;
        got++;
      end
    end
    if (got < 9) checkOutput($sformatf("v%0d tick count", idx), got, 9);
    bus.enable = 1'b0;
    stepClock();
    checkOutput($sformatf("v%0d disabled data", idx), int'(bus.data_out), int'(v.lo));
    checkOutput($sformatf("v%0d disabled done", idx), int'(bus.cycle_done), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.cfg_load  = 1'b0;
    bus.cfg_amp   = '0;
    bus.cfg_mean  = '0;
    bus.cfg_step  = '0;
    bus.cfg_div   = '0;
    bus.cfg_shape = '0;

    vecs[0] = '{2'd0, 12'd100, 12'd2000, 12'd50, 16'd0, 12'd2100, 12'd1900,
                {12'd1900, 12'd1950, 12'd2000, 12'd2050, 12'd2100, 12'd2050, 12'd2000, 12'd1950, 12'd1900},
                9'b000000001};
    vecs[1] = '{2'd0, 12'd200, 12'd4000, 12'd100, 16'd0, 12'd4095, 12'd3800,
                {12'd3800, 12'd3900, 12'd4000, 12'd4095, 12'd3995, 12'd3895, 12'd3800, 12'd3900, 12'd4000},
                9'b000000100};
    vecs[2] = '{2'd0, 12'd300, 12'd100, 12'd64, 16'd0, 12'd400, 12'd0,
                {12'd0, 12'd64, 12'd128, 12'd192, 12'd256, 12'd320, 12'd384, 12'd400, 12'd336},
                9'b000000000};
    vecs[3] = '{2'd1, 12'd100, 12'd2000, 12'd50, 16'd3, 12'd2100, 12'd1900,
                {12'd1900, 12'd2100, 12'd2100, 12'd2100, 12'd2100, 12'd1900, 12'd1900, 12'd1900, 12'd1900},
                9'b000000001};
    vecs[4] = '{2'd2, 12'd100, 12'd2000, 12'd100, 16'd1, 12'd2100, 12'd1900,
                {12'd1900, 12'd2000, 12'd2100, 12'd1900, 12'd2000, 12'd2100, 12'd1900, 12'd2000, 12'd2100},
                9'b000100100};
    vecs[5] = '{2'd3, 12'd100, 12'd1234, 12'd10, 16'd0, 12'd1334, 12'd1134,
                {12'd1134, 12'd1234, 12'd1234, 12'd1234, 12'd1234, 12'd1234, 12'd1234, 12'd1234, 12'd1234},
                9'b000000000};
    vecs[6] = '{2'd0, 12'd2, 12'd10, 12'd0, 16'd0, 12'd12, 12'd8,
                {12'd8, 12'd9, 12'd10, 12'd11, 12'd12, 12'd11, 12'd10, 12'd9, 12'd8},
                9'b000000001};
    vecs[7] = '{2'd0, 12'd0, 12'd500, 12'd20, 16'd0, 12'd500, 12'd500,
                {12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500, 12'd500},
                9'b000000000};

    #13;
    checkOutput("reset data_out", int'(bus.data_out), 0);
    checkOutput("reset sample_tick", int'(bus.sample_tick), 0);
    checkOutput("reset cycle_done", int'(bus.cycle_done), 0);
    checkOutput("reset cfg_pending", int'(bus.cfg_pending), 0);
    checkOutput("reset hi_lvl", int'(bus.hi_lvl), 0);
    checkOutput("reset lo_lvl", int'(bus.lo_lvl), 0);
    stepClock();
    rst_n = 1'b1;
    stepClock();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reconfigure mid-rise: old waveform finishes, new bounds land on the return to lo.
    loadCfg(2'd0, 12'd100, 12'd2000, 12'd50, 16'd0);
    bus.enable = 1'b1;
    repeat (3) stepClock();
    checkOutput("midcfg pre data", int'(bus.data_out), 2000);
    bus.cfg_amp  = 12'd50;
    bus.cfg_load = 1'b1;
    stepClock();
    bus.cfg_load = 1'b0;
    checkOutput("midcfg pending set", int'(bus.cfg_pending), 1);
    checkOutput("midcfg old data", int'(bus.data_out), 2050);
    checkOutput("midcfg old hi", int'(bus.hi_lvl), 2100);
    repeat (5) stepClock();
    checkOutput("midcfg boundary data", int'(bus.data_out), 1900);
    checkOutput("midcfg boundary done", int'(bus.cycle_done), 1);
    checkOutput("midcfg new hi", int'(bus.hi_lvl), 2050);
    checkOutput("midcfg new lo", int'(bus.lo_lvl), 1950);
    checkOutput("midcfg pending clr", int'(bus.cfg_pending), 0);
    stepClock();
    checkOutput("midcfg new rise", int'(bus.data_out), 2000);
    bus.enable = 1'b0;
    stepClock();
    checkOutput("midcfg idle lo", int'(bus.data_out), 1950);

    // Asynchronous reset in the falling half, checked between clock edges.
    loadCfg(2'd0, 12'd100, 12'd2000, 12'd50, 16'd5);
    bus.enable = 1'b1;
    for (int t = 0; t < 6; t++) waitTick("rstfall");
    checkOutput("rstfall pre data", int'(bus.data_out), 2050);
    repeat (2) stepClock();
    rst_n = 1'b0;
    #2;
    checkOutput("rstfall data_out", int'(bus.data_out), 0);
    checkOutput("rstfall sample_tick", int'(bus.sample_tick), 0);
    checkOutput("rstfall cycle_done", int'(bus.cycle_done), 0);
    checkOutput("rstfall hi_lvl", int'(bus.hi_lvl), 0);
    checkOutput("rstfall lo_lvl", int'(bus.lo_lvl), 0);
    bus.enable = 1'b0;
    rst_n = 1'b1;
    stepClock();
    loadCfg(2'd0, 12'd100, 12'd2000, 12'd50, 16'd5);
    bus.enable = 1'b1;
    waitTick("restart0");
    checkOutput("restart first", int'(bus.data_out), 1900);
    waitTick("restart1");
    checkOutput("restart second", int'(bus.data_out), 1950);
    bus.enable = 1'b0;
    stepClock();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/wave_synth.md
Name: wave_synth

Overview:
- Test-signal generator for the oscilloscope datapath; it is the producer side of the 12-bit sample stream that the amplitude/mean measurement logic consumes.
- Synthesises triangle, square or sawtooth waveforms from a programmed amplitude, mean, per-sample step and sample-rate divider.
- Output is one 12-bit unsigned sample per sample tick, for the DAC driver or for loop-back into the measurement path.
- New configuration takes effect only at a cycle boundary, so the output never glitches mid-period.

Parameters:
- DW, 12, sample width; full scale is 2^DW-1 = 4095.
- DIV_W, 16, width of the sample-rate divider.
- CLK_FREQ, 1000000, system clock in Hz; informational only.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  run the generator; low means idle.
- cfg_load  in  1  one-cycle strobe; captures all cfg_* into the shadow set.
- cfg_amp  in  DW  peak amplitude, unsigned.
- cfg_mean  in  DW  centre level, unsigned.
- cfg_step  in  DW  per-sample increment; 0 is treated as 1.
- cfg_div  in  DIV_W  sample period is cfg_div+1 clocks.
- cfg_shape  in  2  0 = triangle, 1 = square, 2 = sawtooth, 3 = constant mean.
- data_out  out  DW  current sample.
- sample_tick  out  1  one-cycle pulse, coincident with each new data_out value.
- cycle_done  out  1  one-cycle pulse when a period completes.
- cfg_pending  out  1  shadow configuration is waiting to be applied.
- hi_lvl  out  DW  active clamped upper bound.
- lo_lvl  out  DW  active clamped lower bound.

Behaviour:
- Reset values: data_out=0, sample_tick=0, cycle_done=0, cfg_pending=0, hi_lvl=0, lo_lvl=0; shadow and active config all 0; state IDLE; divider 0.
- Bounds are computed in DW+1 bits:
  - hi = min(mean+amp, 4095).
  - lo = max(mean-amp, 0); if amp > mean, lo = 0.
  - Bounds are registered when the active config is loaded.
- Divider: counts 0..div while enable is high; a tick occurs when the count equals div, after which the count returns to 0. With div=0 there is a tick every clock.
- All output updates are registered; data_out and sample_tick change on the same edge.
- State IDLE (enable low, or after reset):
  - Divider held at 0; data_out = lo_lvl.
  - cfg_load copies shadow to active immediately; cfg_pending stays 0.
  - On the first tick after enable goes high: output lo, go to RISE. If hi==lo or shape==3, go to HOLD instead.
- State RISE, on each tick: acc = min(acc+step, hi).
  - Output per shape: triangle = acc; sawtooth = acc; square = hi.
  - When acc reaches hi: triangle/square go to FALL; sawtooth goes to WRAP.
- State FALL, on each tick: acc = max(acc-step, lo).
  - Output per shape: triangle = acc; square = lo.
  - When acc reaches lo: pulse cycle_done and go to BOUNDARY handling.
- State WRAP: on the next tick, output lo, pulse cycle_done, go to BOUNDARY handling.
- BOUNDARY handling, in the same cycle: if cfg_pending, load shadow to active, recompute hi/lo, clear cfg_pending; then go to RISE, or HOLD if hi==lo.
- State HOLD: data_out = mean clamped to the range 0..4095; no cycle_done. Any cfg_load is applied on the next tick.
- cfg_load while running: shadow is overwritten and cfg_pending is set. The last load before the boundary wins.
- Simultaneous cfg_load and boundary: the boundary applies the old shadow; the new value stays pending.
- enable falling mid-period: next cycle is IDLE, data_out = lo_lvl, no cycle_done.
- rst_n asserted mid-operation: all outputs are reset immediately, without waiting for a clock.
- Period lengths, with N = ceil((hi-lo)/step):
  - Triangle and square: 2N ticks.
  - Sawtooth: N+1 ticks.

Decomposition:
- Package wave_pkg holds:
  - DW and the full-scale constant 4095.
  - shape_t enum: TRI, SQR, SAW, DC.
  - state_t enum: IDLE, RISE, FALL, WRAP, HOLD.
  - Saturating add/sub functions.
- Sub-module sample_divider: takes clk, rst_n, enable and div; produces tick.

Test Plan:
- Reset, then enable, triangle, amp=100, mean=2000, step=50, div=0 -> data_out sequence 1900,1950,2000,2050,2100,2050,2000,1950,1900,...; cycle_done on every 8th tick; hi_lvl=2100, lo_lvl=1900.
- Clamping: mean=4000, amp=200 -> hi_lvl=4095, lo_lvl=3800; mean=100, amp=300 -> lo_lvl=0, hi_lvl=400; with step=64 the last rise sample is 400 (clamped), not 448.
- Square, amp=100, mean=2000, step=50, div=3 -> 4 ticks at 2100 then 4 at 1900; sample_tick every 4 clocks.
- Sawtooth, step=100, same bounds -> 1900, 2000, 2100, 1900 (WRAP); cycle_done on the wrap sample; period 3 ticks.
- cfg_load of amp=50 at mid-rise -> cfg_pending=1 and the old waveform continues; on returning to 1900, new bounds 1950/2050 apply and cfg_pending=0.
- rst_n low mid-FALL with div=5 -> data_out=0 and flags cleared without a clock edge; after release and enable, the sequence restarts from lo.
